sensor_adc_sequencer: RTL and testbench

Sequences one averaged measurement of the radiation sensor through the ADC. It sits between the ISO/IEC 14443A application adapter and the analogue sensor/ADC pins. It takes a single start request plus a sensor configuration and drives the sensor/ADC enable and read strobes. It then accumulates 2^AVG_LOG2 conversions and returns their mean, or an error flag on timeout.

---
 rtl/sensor_adc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sensor_adc_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_adc_sequencer.sv
// Measurement sequencer for the radiation sensor.
// One accepted start powers up the sensor and ADC, then runs 2^AVG_LOG2
// read/convert/release rounds and reports the truncated mean on a done pulse.
// If the ADC handshake stalls, it reports done together with error instead.
module sensor_adc_sequencer #(
  parameter int SETTLE_TICKS  = 64,
  parameter int READ_TICKS    = 4,
  parameter int TIMEOUT_TICKS = 4096,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [2:0]  cfg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] result_o,
  output logic [2:0]  sens_config_o,
  output logic        sens_enable_o,
  output logic        adc_enable_o,
  output logic        sens_read_o,
  output logic        adc_read_o,
  input  logic        adc_conversion_complete_i,
  input  logic [15:0] adc_value_i
);

  localparam int MAX_SR = (SETTLE_TICKS > READ_TICKS) ? SETTLE_TICKS : READ_TICKS;
  localparam int MAXT   = (MAX_SR > TIMEOUT_TICKS) ? MAX_SR : TIMEOUT_TICKS;
  localparam int CW     = $clog2(MAXT) + 1;
  localparam int AW     = 16 + AVG_LOG2;
  localparam int NW     = AVG_LOG2 + 1;
  localparam logic [NW-1:0] NSAMP = NW'(1) << AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE, POWER_UP, READ, WAIT_CONV, RELEASE, FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [NW-1:0]   nsmp_q, nsmp_d;
  logic [2:0]      cfg_q, cfg_d;
  logic            err_d;
  logic            active_d;
  logic [AW-1:0]   acc_shift;
  logic            busy_q, done_q, error_q, en_q, rd_q;
  logic [15:0]     result_q;

  // Mean is taken from the accumulator as it stands when FINISH is entered;
  // the last capture happened at least one edge earlier (WAIT_CONV->RELEASE).
  assign acc_shift = acc_q >> AVG_LOG2;

  // Next-state logic; cnt counts cycles spent in the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    acc_d   = acc_q;
    nsmp_d  = nsmp_q;
    cfg_d   = cfg_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_i && !abort_i) begin
          state_d = POWER_UP;
          cfg_d   = cfg_i;
          acc_d   = '0;
          nsmp_d  = '0;
        end
      end
      POWER_UP: begin
        if (cnt_q == CW'(SETTLE_TICKS - 1)) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == CW'(READ_TICKS - 1)) begin
          state_d = WAIT_CONV;
          cnt_d   = '0;
        end
      end
      WAIT_CONV: begin
        if (adc_conversion_complete_i) begin
          acc_d   = acc_q + AW'(adc_value_i);
          nsmp_d  = nsmp_q + NW'(1);
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
          state_d = FINISH;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (!adc_conversion_complete_i) begin
          state_d = (nsmp_q == NSAMP) ? FINISH : READ;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
          state_d = FINISH;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Abort wins over every transition except leaving IDLE, where it already
    // blocks the start above.
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = 1'b0;
    end
    active_d = (state_d == POWER_UP) || (state_d == READ) ||
               (state_d == WAIT_CONV) || (state_d == RELEASE);
  end

  // State and output registers; outputs decode the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      nsmp_q   <= '0;
      cfg_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      en_q     <= 1'b0;
      rd_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      nsmp_q  <= nsmp_d;
      cfg_q   <= cfg_d;
      busy_q  <= active_d;
      en_q    <= active_d;
      rd_q    <= (state_d == READ);
      done_q  <= (state_d == FINISH);
      error_q <= (state_d == FINISH) && err_d;
      if (state_d == FINISH && !err_d) result_q <= acc_shift[15:0];
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign result_o      = result_q;
  assign sens_config_o = cfg_q;
  assign sens_enable_o = en_q;
  assign adc_enable_o  = en_q;
  assign sens_read_o   = rd_q;
  assign adc_read_o    = rd_q;

endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Directed bench: three sequencer instances (AVG_LOG2 = 2, 0, 4) share clock,
// reset, abort, cfg and the ADC handshake; a table of measurements is run
// through a cycle-level ADC responder, plus hand-written corner sequences.
module tb_sensor_adc_sequencer;

  localparam int SETTLE = 4;
  localparam int READT  = 2;
  localparam int TMO    = 16;

  logic        clk, rst, abort, adc_c;
  logic [2:0]  cfg;
  logic [15:0] adc_v;
  logic        start [3];
  logic        busy [3], done [3], error [3], sen [3], aen [3], srd [3], ard [3];
  logic [15:0] result [3];
  logic [2:0]  scfg [3];

  int n_cmp = 0;
  int n_fail = 0;
  int sel = 0;
  logic [15:0] last_res [3];

  sensor_adc_sequencer #(.SETTLE_TICKS(SETTLE), .READ_TICKS(READT), .TIMEOUT_TICKS(TMO), .AVG_LOG2(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .abort_i(abort), .cfg_i(cfg),
    .busy_o(busy[0]), .done_o(done[0]), .error_o(error[0]), .result_o(result[0]),
    .sens_config_o(scfg[0]), .sens_enable_o(sen[0]), .adc_enable_o(aen[0]),
    .sens_read_o(srd[0]), .adc_read_o(ard[0]),
    .adc_conversion_complete_i(adc_c), .adc_value_i(adc_v));

  sensor_adc_sequencer #(.SETTLE_TICKS(SETTLE), .READ_TICKS(READT), .TIMEOUT_TICKS(TMO), .AVG_LOG2(0)) dut_a0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .abort_i(abort), .cfg_i(cfg),
    .busy_o(busy[1]), .done_o(done[1]), .error_o(error[1]), .result_o(result[1]),
    .sens_config_o(scfg[1]), .sens_enable_o(sen[1]), .adc_enable_o(aen[1]),
    .sens_read_o(srd[1]), .adc_read_o(ard[1]),
    .adc_conversion_complete_i(adc_c), .adc_value_i(adc_v));

  sensor_adc_sequencer #(.SETTLE_TICKS(SETTLE), .READ_TICKS(READT), .TIMEOUT_TICKS(TMO), .AVG_LOG2(4)) dut_a4 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .abort_i(abort), .cfg_i(cfg),
    .busy_o(busy[2]), .done_o(done[2]), .error_o(error[2]), .result_o(result[2]),
    .sens_config_o(scfg[2]), .sens_enable_o(sen[2]), .adc_enable_o(aen[2]),
    .sens_read_o(srd[2]), .adc_read_o(ard[2]),
    .adc_conversion_complete_i(adc_c), .adc_value_i(adc_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              sel;
    logic [2:0]      cfg;
    int              dly;    // WAIT_CONV cycles until complete rises
    int              hold;   // edges complete stays high
    int              mode;   // 0 normal, 1 never complete, 2 stuck after sample 2
    logic [3:0][15:0] v;
    logic            exp_err;
    logic [15:0]     exp_res;
    int              exp_cyc; // start edge to done cycle
    int              exp_reads;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] outs(input int s);
    return {4'd0, busy[s], done[s], error[s], result[s], scfg[s], sen[s], aen[s], srd[s], ard[s]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Start one measurement on instance t.sel, act as the ADC cycle by cycle,
  // and check strobes, timing and the done-cycle outputs.
  task automatic run_meas(input string nm, input vec_t t, input int abort_at, input bit spam);
    int k, rises, width, width_bad, bad_pair, bad_en, first_rise, phase, wcnt, hcnt, ci, dseen;
    bit rd, prev_rd, got_done, aborted;
    rises = 0; width = 0; width_bad = 0; bad_pair = 0; bad_en = 0; first_rise = 0;
    phase = 0; wcnt = 0; hcnt = 0; ci = 0; prev_rd = 0; got_done = 0; aborted = 0;
    sel = t.sel;
    adc_c = 1'b0; adc_v = 16'h0;
    @(negedge clk);
    start[t.sel] = 1'b1; cfg = t.cfg;
    @(negedge clk);
    start[t.sel] = spam;
    chk({nm, "_busy_after_start"}, {31'd0, busy[t.sel]}, 32'd1);
    for (k = 1; k <= 400; k++) begin
      if (k > 1) @(negedge clk);
      rd = srd[t.sel];
      if (srd[t.sel] !== ard[t.sel] || sen[t.sel] !== aen[t.sel]) bad_pair++;
      if (sen[t.sel] !== busy[t.sel]) bad_en++;
      if (rd && !prev_rd) begin
        rises++; width = 0;
        if (rises == 1) first_rise = k;
      end
      if (rd) width++;
      if (!rd && prev_rd && width != READT) width_bad++;
      if (done[t.sel]) begin got_done = 1; break; end
      if (abort_at != 0 && rd && !prev_rd && rises == abort_at) begin
        abort = 1'b1; aborted = 1; break;
      end
      if (phase == 2) begin
        hcnt++;
        if (hcnt >= t.hold && !(t.mode == 2 && ci == 1)) begin
          adc_c = 1'b0; phase = 0; ci++;
        end
      end
      if (!rd && prev_rd) begin phase = 1; wcnt = 0; end
      if (phase == 1) begin
        wcnt++;
        if (t.mode != 1 && wcnt == t.dly) begin
          adc_c = 1'b1; adc_v = t.v[ci & 3]; phase = 2; hcnt = 0;
        end
      end
      prev_rd = rd;
    end
    if (aborted) begin
      @(negedge clk);
      abort = 1'b0;
      adc_c = 1'b0;
      chk({nm, "_abort_quiet"}, {27'd0, busy[t.sel], done[t.sel], sen[t.sel] | aen[t.sel], srd[t.sel], ard[t.sel]}, 32'd0);
      chk({nm, "_abort_result"}, {16'd0, result[t.sel]}, {16'd0, last_res[t.sel]});
      dseen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done[t.sel] || busy[t.sel]) dseen++;
      end
      chk({nm, "_abort_no_done"}, dseen, 0);
    end else if (!got_done) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", nm);
    end else begin
      chk({nm, "_cycles"}, k, t.exp_cyc);
      chk({nm, "_error"}, {31'd0, error[t.sel]}, {31'd0, t.exp_err});
      chk({nm, "_result"}, {16'd0, result[t.sel]}, {16'd0, t.exp_res});
      chk({nm, "_sens_config"}, {29'd0, scfg[t.sel]}, {29'd0, t.cfg});
      chk({nm, "_done_quiet"}, {28'd0, busy[t.sel], sen[t.sel] | aen[t.sel], srd[t.sel], ard[t.sel]}, 32'd0);
      chk({nm, "_reads"}, rises, t.exp_reads);
      chk({nm, "_read_width"}, width_bad, 0);
      chk({nm, "_pairs"}, bad_pair, 0);
      chk({nm, "_enable_vs_busy"}, bad_en, 0);
      chk({nm, "_first_read"}, first_rise, SETTLE + 1);
      if (!t.exp_err) last_res[t.sel] = t.exp_res;
      // start held across the done cycle must not be taken there
      start[t.sel] = spam;
      adc_c = 1'b0;
      @(negedge clk);
      chk({nm, "_after_done"}, {29'd0, done[t.sel], error[t.sel], busy[t.sel]}, 32'd0);
      if (spam) begin
        @(negedge clk);
        chk({nm, "_accept_after_done"}, {31'd0, busy[t.sel]}, 32'd1);
        start[t.sel] = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk({nm, "_abort_powerup"}, {31'd0, busy[t.sel]}, 32'd0);
      end
      start[t.sel] = 1'b0;
    end
  endtask

  initial begin
    vec_t tv;
    rst = 1'b1; abort = 1'b0; adc_c = 1'b0; adc_v = '0; cfg = '0;
    for (int i = 0; i < 3; i++) begin start[i] = 1'b0; last_res[i] = 16'h0; end

    //          sel cfg    dly hold mode values (v3..v0)                                 err   result     cyc reads
    vecs[0] = '{0, 3'b101, 3, 2, 0, {16'd401, 16'd300, 16'd200, 16'd100},               1'b0, 16'd250,    33, 4};
    vecs[1] = '{0, 3'b010, 1, 1, 1, {16'd9, 16'd9, 16'd9, 16'd9},                       1'b1, 16'd250,    23, 1};
    vecs[2] = '{0, 3'b111, 1, 1, 2, {16'd7, 16'd7, 16'd7, 16'd7},                       1'b1, 16'd250,    28, 2};
    vecs[3] = '{0, 3'b001, 1, 1, 0, {16'h4003, 16'h3000, 16'h2000, 16'h1000},           1'b0, 16'h2800,   21, 4};
    vecs[4] = '{0, 3'b000, 2, 3, 0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},           1'b0, 16'hFFFF,   33, 4};
    vecs[5] = '{1, 3'b011, 1, 1, 0, {16'h0, 16'h0, 16'h0, 16'hFFFF},                    1'b0, 16'hFFFF,    9, 1};
    vecs[6] = '{2, 3'b110, 1, 1, 0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},           1'b0, 16'hFFFF,   69, 16};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_state_%0d", i), outs(i), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_meas($sformatf("row%0d", i), vecs[i], 0, 1'b0);

    // abort on the third read strobe, then a clean measurement
    tv = vecs[0];
    tv.cfg = 3'b100;
    run_meas("abort3", tv, 3, 1'b0);
    tv = '{0, 3'b110, 1, 1, 0, {16'd9, 16'd8, 16'd8, 16'd8}, 1'b0, 16'd8, 21, 4};
    run_meas("after_abort", tv, 0, 1'b0);

    // start held high for the whole measurement and across done
    tv = '{0, 3'b011, 2, 1, 0, {16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 16'd25, 25, 4};
    run_meas("spam", tv, 0, 1'b1);

    // start and abort together in IDLE: nothing happens
    @(negedge clk);
    start[0] = 1'b1; abort = 1'b1; cfg = 3'b111;
    @(negedge clk);
    start[0] = 1'b0; abort = 1'b0;
    chk("start_abort_same", {27'd0, busy[0], sen[0], srd[0], scfg[0] == 3'b111 ? 1'b1 : 1'b0, done[0]}, 32'd0);
    repeat (2) @(negedge clk);
    chk("start_abort_later", {30'd0, busy[0], sen[0]}, 32'd0);

    // reset in the middle of WAIT_CONV
    adc_c = 1'b0;
    start[0] = 1'b1; cfg = 3'b101;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (SETTLE + READT + 2) @(negedge clk);
    chk("pre_reset_busy", {30'd0, busy[0], srd[0]}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_wait", outs(0), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_stays_idle", outs(0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
